// File: rtl/pe_dual_dataflow.sv
// Systolic-mesh processing element supporting weight-stationary and output-stationary
// dataflow, with one registered stage per PE and a sticky accumulator-overflow flag.
module pe_dual_dataflow #(
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 32,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  in_a,
    input  logic                 in_a_valid,
    input  logic [IN_WIDTH-1:0]  in_b,
    input  logic                 in_b_valid,
    input  logic [ACC_WIDTH-1:0] in_d,
    input  logic                 in_d_valid,
    input  logic                 in_dataflow,
    input  logic                 in_propagate,
    output logic [IN_WIDTH-1:0]  out_a,
    output logic                 out_a_valid,
    output logic [IN_WIDTH-1:0]  out_b,
    output logic                 out_b_valid,
    output logic [ACC_WIDTH-1:0] out_d,
    output logic                 out_d_valid,
    output logic                 out_dataflow,
    output logic                 out_propagate,
    output logic                 out_overflow
);
    localparam int PW = 2 * IN_WIDTH;
    localparam int SW = ACC_WIDTH + 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [IN_WIDTH-1:0]  w0_q, w0_d, w1_q, w1_d;
    logic                 w0_v_q, w0_v_d, w1_v_q, w1_v_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 acc_v_q, acc_v_d;
    logic                 df_q, ovf_q, ovf_d;
    logic [IN_WIDTH-1:0]  out_a_q, out_b_q, out_b_d;
    logic                 out_a_v_q, out_b_v_q, out_b_v_d;
    logic [ACC_WIDTH-1:0] out_d_q, out_d_d;
    logic                 out_d_v_q, out_d_v_d;
    logic                 out_df_q, out_prop_q;

    logic                 mode_chg, w0_v_eff, w1_v_eff, acc_v_eff, act_v;
    logic [IN_WIDTH-1:0]  act_w, mul_b;
    logic [ACC_WIDTH-1:0] addend, sum_res;
    logic signed [PW-1:0] prod;
    logic [SW-1:0]        sum;
    logic                 sum_ovf;

    // One multiplier/adder serves both modes: WS adds in_d to a*weight, OS adds acc to a*b.
    always_comb begin
        mode_chg  = in_dataflow ^ df_q;
        w0_v_eff  = w0_v_q & ~mode_chg;
        w1_v_eff  = w1_v_q & ~mode_chg;
        acc_v_eff = acc_v_q & ~mode_chg;
        act_w     = in_propagate ? w0_q : w1_q;
        act_v     = in_propagate ? w0_v_eff : w1_v_eff;
        mul_b     = in_dataflow ? act_w : in_b;
        addend    = in_dataflow ? in_d : acc_q;
        prod      = $signed(in_a) * $signed(mul_b);
        sum       = {{(SW-PW){prod[PW-1]}}, prod} + {addend[ACC_WIDTH-1], addend};
        sum_ovf   = sum[SW-1] ^ sum[SW-2];
        if (sum_ovf && SATURATE) sum_res = sum[SW-1] ? ACC_MIN : ACC_MAX;
        else                     sum_res = sum[ACC_WIDTH-1:0];
    end

    always_comb begin
        w0_d      = w0_q;
        w1_d      = w1_q;
        w0_v_d    = w0_v_eff;
        w1_v_d    = w1_v_eff;
        acc_d     = acc_q;
        acc_v_d   = acc_v_eff;
        ovf_d     = ovf_q;
        out_b_d   = in_b;
        out_b_v_d = in_b_valid;
        out_d_d   = '0;
        out_d_v_d = 1'b0;
        if (in_dataflow) begin
            // Load bank is always the one not being computed on; its old contents shift south.
            out_b_d   = in_propagate ? w1_q : w0_q;
            out_b_v_d = in_propagate ? w1_v_eff : w0_v_eff;
            if (in_b_valid) begin
                if (in_propagate) begin
                    w1_d   = in_b;
                    w1_v_d = ~mode_chg;
                end else begin
                    w0_d   = in_b;
                    w0_v_d = ~mode_chg;
                end
            end
            out_d_d   = sum_res;
            out_d_v_d = in_a_valid & in_d_valid & act_v;
            if (out_d_v_d && sum_ovf) ovf_d = 1'b1;
        end else if (in_propagate) begin
            out_d_d   = acc_q;
            out_d_v_d = acc_v_eff;
            acc_d     = in_d;
            acc_v_d   = in_d_valid & ~mode_chg;
        end else if (in_a_valid && in_b_valid && acc_v_eff) begin
            acc_d = sum_res;
            if (sum_ovf) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w0_q       <= '0;
            w1_q       <= '0;
            w0_v_q     <= 1'b0;
            w1_v_q     <= 1'b0;
            acc_q      <= '0;
            acc_v_q    <= 1'b0;
            df_q       <= 1'b0;
            ovf_q      <= 1'b0;
            out_a_q    <= '0;
            out_a_v_q  <= 1'b0;
            out_b_q    <= '0;
            out_b_v_q  <= 1'b0;
            out_d_q    <= '0;
            out_d_v_q  <= 1'b0;
            out_df_q   <= 1'b0;
            out_prop_q <= 1'b0;
        end else begin
            w0_q       <= w0_d;
            w1_q       <= w1_d;
            w0_v_q     <= w0_v_d;
            w1_v_q     <= w1_v_d;
            acc_q      <= acc_d;
            acc_v_q    <= acc_v_d;
            df_q       <= in_dataflow;
            ovf_q      <= ovf_d;
            out_a_q    <= in_a;
            out_a_v_q  <= in_a_valid;
            out_b_q    <= out_b_d;
            out_b_v_q  <= out_b_v_d;
            out_d_q    <= out_d_d;
            out_d_v_q  <= out_d_v_d;
            out_df_q   <= in_dataflow;
            out_prop_q <= in_propagate;
        end
    end

    assign out_a         = out_a_q;
    assign out_a_valid   = out_a_v_q;
    assign out_b         = out_b_q;
    assign out_b_valid   = out_b_v_q;
    assign out_d         = out_d_q;
    assign out_d_valid   = out_d_v_q;
    assign out_dataflow  = out_df_q;
    assign out_propagate = out_prop_q;
    assign out_overflow  = ovf_q;
endmodule

// File: tb/tb_pe_dual_dataflow.sv
// Directed bench for pe_dual_dataflow: 32-bit accumulator instance driven from a vector
// table, plus 16-bit saturating and wrapping instances for overflow and reset sequences.
module tb_pe_dual_dataflow;
    logic        clock, reset;
    logic [7:0]  in_a, in_b;
    logic        in_a_valid, in_b_valid, in_d_valid, in_dataflow, in_propagate;
    logic [31:0] in_d;

    logic [7:0]  m_a, m_b, s_a, s_b, w_a, w_b;
    logic        m_av, m_bv, m_dv, m_df, m_pr, m_ov;
    logic        s_av, s_bv, s_dv, s_df, s_pr, s_ov;
    logic        w_av, w_bv, w_dv, w_df, w_pr, w_ov;
    logic [31:0] m_d;
    logic [15:0] s_d, w_d;

    pe_dual_dataflow #(.IN_WIDTH(8), .ACC_WIDTH(32), .SATURATE(1'b1)) dut (
        .clock(clock), .reset(reset),
        .in_a(in_a), .in_a_valid(in_a_valid), .in_b(in_b), .in_b_valid(in_b_valid),
        .in_d(in_d), .in_d_valid(in_d_valid), .in_dataflow(in_dataflow), .in_propagate(in_propagate),
        .out_a(m_a), .out_a_valid(m_av), .out_b(m_b), .out_b_valid(m_bv),
        .out_d(m_d), .out_d_valid(m_dv), .out_dataflow(m_df), .out_propagate(m_pr),
        .out_overflow(m_ov));

    pe_dual_dataflow #(.IN_WIDTH(8), .ACC_WIDTH(16), .SATURATE(1'b1)) dut_s (
        .clock(clock), .reset(reset),
        .in_a(in_a), .in_a_valid(in_a_valid), .in_b(in_b), .in_b_valid(in_b_valid),
        .in_d(in_d[15:0]), .in_d_valid(in_d_valid), .in_dataflow(in_dataflow), .in_propagate(in_propagate),
        .out_a(s_a), .out_a_valid(s_av), .out_b(s_b), .out_b_valid(s_bv),
        .out_d(s_d), .out_d_valid(s_dv), .out_dataflow(s_df), .out_propagate(s_pr),
        .out_overflow(s_ov));

    pe_dual_dataflow #(.IN_WIDTH(8), .ACC_WIDTH(16), .SATURATE(1'b0)) dut_w (
        .clock(clock), .reset(reset),
        .in_a(in_a), .in_a_valid(in_a_valid), .in_b(in_b), .in_b_valid(in_b_valid),
        .in_d(in_d[15:0]), .in_d_valid(in_d_valid), .in_dataflow(in_dataflow), .in_propagate(in_propagate),
        .out_a(w_a), .out_a_valid(w_av), .out_b(w_b), .out_b_valid(w_bv),
        .out_d(w_d), .out_d_valid(w_dv), .out_dataflow(w_df), .out_propagate(w_pr),
        .out_overflow(w_ov));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        df, prop;
        logic [7:0]  a;
        logic        av;
        logic [7:0]  b;
        logic        bv;
        logic [31:0] d;
        logic        dv;
        logic [31:0] ed;
        logic        edv;
        logic [7:0]  eb;
        logic        ebv;
    } vec_t;

    int n_pass = 0;
    int n_tot  = 0;
    vec_t tbl[30];

    function automatic vec_t mk(input int df, prop, a, av, b, bv, d, dv, ed, edv, eb, ebv);
        vec_t v;
        v.df = 1'(df);  v.prop = 1'(prop);
        v.a  = 8'(a);   v.av   = 1'(av);
        v.b  = 8'(b);   v.bv   = 1'(bv);
        v.d  = 32'(d);  v.dv   = 1'(dv);
        v.ed = 32'(ed); v.edv  = 1'(edv);
        v.eb = 8'(eb);  v.ebv  = 1'(ebv);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic drive(input int df, prop, a, av, b, bv, d, dv);
        in_dataflow = 1'(df);  in_propagate = 1'(prop);
        in_a = 8'(a); in_a_valid = 1'(av);
        in_b = 8'(b); in_b_valid = 1'(bv);
        in_d = 32'(d); in_d_valid = 1'(dv);
    endtask

    initial begin
        //              df pr   a av    b bv      d dv     ed edv   eb ebv
        tbl[0]  = mk(1, 0,   0, 0,   0, 0,     0, 0,     0, 0,    0, 0); // enter WS
        tbl[1]  = mk(1, 0,   0, 0,   3, 1,     0, 0,     0, 0,    0, 0); // w0 <= 3
        tbl[2]  = mk(1, 1,   5, 1,   0, 0,    10, 1,    25, 1,    0, 0);
        tbl[3]  = mk(1, 0,   0, 0,   9, 1,     0, 0,     0, 0,    3, 1);
        tbl[4]  = mk(1, 0,   0, 0,  -2, 1,     0, 0,     0, 0,    9, 1);
        tbl[5]  = mk(1, 1,   4, 1,   0, 0,     0, 1,    -8, 1,    0, 0);
        tbl[6]  = mk(1, 1,   0, 0,   6, 1,     0, 0,     0, 0,    0, 0); // w1 <= 6
        tbl[7]  = mk(1, 0,   3, 1,   0, 0,     1, 1,    19, 1,   -2, 1);
        tbl[8]  = mk(1, 0,   2, 0,   0, 0,     5, 1,    17, 0,   -2, 1);
        tbl[9]  = mk(0, 0,   0, 0,   0, 0,     0, 0,     0, 0,    0, 0); // enter OS
        tbl[10] = mk(0, 1,   0, 0,   0, 0,     0, 1,     0, 0,    0, 0); // bias 0
        tbl[11] = mk(0, 0,   2, 1,   3, 1,     0, 0,     0, 0,    3, 1);
        tbl[12] = mk(0, 0,  -4, 1,   5, 1,     0, 0,     0, 0,    5, 1);
        tbl[13] = mk(0, 0,   7, 1,   1, 1,     0, 0,     0, 0,    1, 1);
        tbl[14] = mk(0, 1,   9, 1,   9, 1,   100, 1,    -7, 1,    9, 1);
        tbl[15] = mk(0, 1,   0, 0,   0, 0,     0, 0,   100, 1,    0, 0);
        tbl[16] = mk(0, 0,   1, 1,   1, 1,     0, 0,     0, 0,    1, 1);
        tbl[17] = mk(0, 1,   0, 0,   0, 0,     0, 0,     0, 0,    0, 0);
        tbl[18] = mk(1, 0,   0, 0,   0, 0,     0, 0,     0, 0,   -2, 0); // back to WS
        tbl[19] = mk(1, 0,   0, 0,   4, 1,     0, 0,     0, 0,   -2, 0);
        tbl[20] = mk(0, 0,   0, 0,   0, 0,     0, 0,     0, 0,    0, 0); // OS excursion
        tbl[21] = mk(1, 1,   5, 1,   0, 0,     1, 1,    21, 0,    6, 0);
        tbl[22] = mk(1, 1,   5, 1,   0, 0,     1, 1,    21, 0,    6, 0);
        tbl[23] = mk(1, 0,   0, 0,   2, 1,     0, 0,     0, 0,    4, 0);
        tbl[24] = mk(1, 1,   5, 1,   0, 0,     1, 1,    11, 1,    6, 0);
        tbl[25] = mk(0, 0,   0, 0,   0, 0,     0, 0,     0, 0,    0, 0);
        tbl[26] = mk(0, 1,   0, 0,   0, 0,    50, 1,     0, 0,    0, 0); // acc <= 50
        tbl[27] = mk(1, 0,   0, 0,   0, 0,     0, 0,     0, 0,    2, 0); // WS excursion
        tbl[28] = mk(0, 0,   1, 1,   1, 1,     0, 0,     0, 0,    1, 1);
        tbl[29] = mk(0, 1,   0, 0,   0, 0,     0, 0,    50, 0,    0, 0);

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst out_d", m_d, 0);
        chk("rst out_d_valid", m_dv, 0);
        chk("rst out_b_valid", m_bv, 0);
        chk("rst out_overflow", m_ov, 0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].df, tbl[i].prop, int'($signed(tbl[i].a)), tbl[i].av,
                  int'($signed(tbl[i].b)), tbl[i].bv, int'(tbl[i].d), tbl[i].dv);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d out_d", i), m_d, tbl[i].ed);
            chk($sformatf("v%0d out_d_valid", i), m_dv, tbl[i].edv);
            chk($sformatf("v%0d out_b", i), m_b, tbl[i].eb);
            chk($sformatf("v%0d out_b_valid", i), m_bv, tbl[i].ebv);
            chk($sformatf("v%0d passthru", i), {m_a, m_av, m_df, m_pr},
                {tbl[i].a, tbl[i].av, tbl[i].df, tbl[i].prop});
            chk($sformatf("v%0d overflow", i), m_ov, 0);
        end

        // Overflow: w0 = 127, then a = 127, d = 32000 in the 16-bit instances.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clock); #1;
        drive(1, 0, 0, 0, 127, 1, 0, 0);
        @(posedge clock); #1;
        drive(1, 1, 127, 0, 0, 0, 32000, 1);
        @(posedge clock); #1;
        chk("sat invalid out_d", s_d, 16'h7FFF);
        chk("sat invalid out_d_valid", s_dv, 0);
        chk("sat invalid no ovf", s_ov, 0);
        drive(1, 1, 127, 1, 0, 0, 32000, 1);
        @(posedge clock); #1;
        chk("sat pos out_d", s_d, 16'h7FFF);
        chk("sat pos ovf", s_ov, 1);
        chk("wrap pos out_d", w_d, 16'hBC01);
        chk("wrap pos ovf", w_ov, 1);
        chk("acc32 pos out_d", m_d, 48129);
        chk("acc32 no ovf", m_ov, 0);
        drive(1, 1, -128, 1, 0, 0, -32768, 1);
        @(posedge clock); #1;
        chk("sat neg out_d", s_d, 16'h8000);
        chk("wrap neg out_d", w_d, 16'h4080);
        chk("acc32 neg out_d", m_d, 32'hFFFF4080);
        chk("sat ovf sticky", s_ov, 1);
        chk("pre-reset out_d_valid", m_dv, 1);

        // Asynchronous reset between edges.
        #2 reset = 1'b0;
        #1;
        chk("async out_d", m_d, 0);
        chk("async out_d_valid", m_dv, 0);
        chk("async out_b", {m_b, m_bv, m_a, m_av, m_df, m_pr}, 0);
        chk("async ovf cleared", {s_ov, w_ov}, 0);
        @(negedge clock);
        reset = 1'b1;
        drive(1, 1, 4, 1, 0, 0, 3, 1);
        @(posedge clock); #1;
        chk("post-rst out_d_valid 1", m_dv, 0);
        @(posedge clock); #1;
        chk("post-rst out_d", m_d, 3);
        chk("post-rst out_d_valid 2", m_dv, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
